// File: rtl/i281_pkg.sv
// Shared definitions for the i281 code memory and its program loader.
package i281_pkg;

    localparam int CM_ADDR_W = 6;
    localparam int CM_DATA_W = 16;
    localparam int USER_BASE = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        WRITE,
        CHK,
        DONE,
        ERR
    } ldr_state_e;

endpackage

// File: rtl/ldr_checksum8.sv
// Mod-256 byte accumulator for the loader frame checksum.
module ldr_checksum8 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] din,
    output logic       match
);

    logic [7:0] sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + din;
        end
    end

    // din doubles as the received CHK byte when compared
    assign match = (sum == din);

endmodule

// File: rtl/code_mem_loader.sv
// Frame-parsing program loader: LEN, N big-endian words, CHK -> code memory writes.
module code_mem_loader
    import i281_pkg::*;
#(
    parameter int ADDR_W    = CM_ADDR_W,
    parameter int DATA_W    = CM_DATA_W,
    parameter int BASE_ADDR = USER_BASE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] cm_addr,
    output logic              cm_we,
    output logic [DATA_W-1:0] cm_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_written
);

    localparam int         MAX_WORDS = (1 << ADDR_W) - BASE_ADDR;
    localparam logic [7:0] MAX_LEN   = 8'(MAX_WORDS);

    ldr_state_e        state;
    logic [ADDR_W-1:0] n_words;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] ww_next;
    logic              xfer;
    logic              ck_clear;
    logic              ck_add;
    logic              ck_match;

    assign xfer     = byte_valid & byte_ready;
    assign ck_clear = (state == IDLE) & start;
    assign ck_add   = xfer & ((state == HI) | (state == LO));
    assign ww_next  = words_written + ADDR_W'(1);

    ldr_checksum8 u_checksum (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (ck_clear),
        .add     (ck_add),
        .din     (byte_data),
        .match   (ck_match)
    );

    // Outputs are registered alongside the state, so each transition sets the
    // output values that belong to the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            n_words       <= '0;
            hi_byte       <= '0;
            byte_ready    <= 1'b0;
            cm_addr       <= '0;
            cm_we         <= 1'b0;
            cm_data       <= '0;
            cpu_hold      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
        end else begin
            cm_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        done          <= 1'b0;
                        error         <= 1'b0;
                        words_written <= '0;
                        busy          <= 1'b1;
                        cpu_hold      <= 1'b1;
                        byte_ready    <= 1'b1;
                        state         <= LEN;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        if ((byte_data == 8'd0) || (byte_data > MAX_LEN)) begin
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            cpu_hold   <= 1'b0;
                            byte_ready <= 1'b0;
                            state      <= ERR;
                        end else begin
                            n_words <= ADDR_W'(byte_data);
                            state   <= HI;
                        end
                    end
                end
                HI: begin
                    if (xfer) begin
                        hi_byte <= byte_data;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (xfer) begin
                        cm_we      <= 1'b1;
                        cm_addr    <= ADDR_W'(BASE_ADDR) + words_written;
                        cm_data    <= DATA_W'({hi_byte, byte_data});
                        byte_ready <= 1'b0;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    words_written <= ww_next;
                    byte_ready    <= 1'b1;
                    state         <= (ww_next == n_words) ? CHK : HI;
                end
                CHK: begin
                    if (xfer) begin
                        busy       <= 1'b0;
                        cpu_hold   <= 1'b0;
                        byte_ready <= 1'b0;
                        if (ck_match) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            error <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
